// File: rtl/llr_replay_tx_if.sv
// Bundle between the link-layer retry responder and its neighbours: retry request
// decode, retry-buffer read port and counters, and the flit path into the packer.
// The master side is the surrounding link layer; the slave side is llr_replay_tx.
interface llr_replay_tx_if #(
  parameter int FLIT_W = 528,
  parameter int PTR_W  = 8
);
  logic              retry_req_valid;
  logic [PTR_W-1:0]  retry_req_eseq;
  logic              replay_abort;
  logic [PTR_W-1:0]  wrt_ptr;
  logic [PTR_W-1:0]  llrb_count;
  logic [4:0]        num_retry;
  logic [4:0]        num_phy_reinit;
  logic              llrb_rd_en;
  logic [PTR_W-1:0]  llrb_rd_addr;
  logic [FLIT_W-1:0] llrb_rd_data;
  logic              flit_valid;
  logic              flit_ready;
  logic              flit_is_ack;
  logic [FLIT_W-1:0] flit_data;
  logic [PTR_W-1:0]  flit_seq;
  logic              ack_empty;
  logic [PTR_W-1:0]  ack_wrt_ptr;
  logic [4:0]        ack_num_retry;
  logic [4:0]        ack_num_phy_reinit;
  logic              replay_busy;
  logic              replay_done;
  logic              eseq_err;

  modport master (
    output retry_req_valid, retry_req_eseq, replay_abort, wrt_ptr, llrb_count,
           num_retry, num_phy_reinit, llrb_rd_data, flit_ready,
    input  llrb_rd_en, llrb_rd_addr, flit_valid, flit_is_ack, flit_data, flit_seq,
           ack_empty, ack_wrt_ptr, ack_num_retry, ack_num_phy_reinit,
           replay_busy, replay_done, eseq_err
  );

  modport slave (
    input  retry_req_valid, retry_req_eseq, replay_abort, wrt_ptr, llrb_count,
           num_retry, num_phy_reinit, llrb_rd_data, flit_ready,
    output llrb_rd_en, llrb_rd_addr, flit_valid, flit_is_ack, flit_data, flit_seq,
           ack_empty, ack_wrt_ptr, ack_num_retry, ack_num_phy_reinit,
           replay_busy, replay_done, eseq_err
  );
endinterface

// File: rtl/llr_replay_tx.sv
// Transmit-side link-layer retry responder. A RETRY.Req produces one RETRY.Ack and
// then a replay of the retry buffer from the requested ESeq up to the write pointer.
// Each replayed flit costs one read cycle (FETCH) plus at least one offer cycle (SEND).
// In the first SEND cycle the flit comes straight from the buffer read port; it is
// also captured so it stays stable for as long as the packer back-pressures.
module llr_replay_tx #(
  parameter int FLIT_W = 528,
  parameter int PTR_W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  llr_replay_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    FETCH = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t            state_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wp_r;
  logic              ack_only_r;
  logic              pend_valid_r;
  logic [PTR_W-1:0]  pend_eseq_r;
  logic [FLIT_W-1:0] hold_r;
  logic              first_r;
  logic              flit_valid_r;
  logic              flit_is_ack_r;
  logic [PTR_W-1:0]  flit_seq_r;
  logic              rd_en_r;
  logic [PTR_W-1:0]  rd_addr_r;
  logic              ack_empty_r;
  logic [PTR_W-1:0]  ack_wrt_ptr_r;
  logic [4:0]        ack_num_retry_r;
  logic [4:0]        ack_num_phy_reinit_r;
  logic              busy_r;
  logic              done_r;
  logic              eseq_err_r;

  logic              req_go_s;
  logic [PTR_W-1:0]  req_eseq_s;
  logic [PTR_W-1:0]  span_s;
  logic              cnt_empty_s;
  logic              window_err_s;
  logic              handshake_s;
  logic [PTR_W-1:0]  rd_next_s;
  logic              restart_s;
  logic              send_last_s;

  // Request selection (a fresh request beats the pending one) and window/handshake decode.
  always_comb begin
    req_go_s     = bus.retry_req_valid | pend_valid_r;
    req_eseq_s   = pend_eseq_r;
    if (bus.retry_req_valid) begin
      req_eseq_s = bus.retry_req_eseq;
    end else begin
      req_eseq_s = pend_eseq_r;
    end
    span_s       = bus.wrt_ptr - req_eseq_s;
    cnt_empty_s  = (bus.llrb_count == '0);
    window_err_s = 1'b0;
    if (cnt_empty_s) begin
      window_err_s = 1'b0;
    end else begin
      window_err_s = (span_s > bus.llrb_count);
    end
    handshake_s  = flit_valid_r & bus.flit_ready;
    rd_next_s    = rd_ptr_r + PTR_W'(1);
    restart_s    = pend_valid_r | bus.retry_req_valid;
    send_last_s  = (rd_next_s == wp_r);
  end

  // Replay FSM with registered outputs; abort clears everything including the pending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r              <= IDLE;
      rd_ptr_r             <= '0;
      wp_r                 <= '0;
      ack_only_r           <= 1'b0;
      pend_valid_r         <= 1'b0;
      pend_eseq_r          <= '0;
      hold_r               <= '0;
      first_r              <= 1'b0;
      flit_valid_r         <= 1'b0;
      flit_is_ack_r        <= 1'b0;
      flit_seq_r           <= '0;
      rd_en_r              <= 1'b0;
      rd_addr_r            <= '0;
      ack_empty_r          <= 1'b0;
      ack_wrt_ptr_r        <= '0;
      ack_num_retry_r      <= '0;
      ack_num_phy_reinit_r <= '0;
      busy_r               <= 1'b0;
      done_r               <= 1'b0;
      eseq_err_r           <= 1'b0;
    end else if (bus.replay_abort) begin
      state_r              <= IDLE;
      pend_valid_r         <= 1'b0;
      hold_r               <= '0;
      first_r              <= 1'b0;
      flit_valid_r         <= 1'b0;
      flit_is_ack_r        <= 1'b0;
      flit_seq_r           <= '0;
      rd_en_r              <= 1'b0;
      rd_addr_r            <= '0;
      ack_empty_r          <= 1'b0;
      ack_wrt_ptr_r        <= '0;
      ack_num_retry_r      <= '0;
      ack_num_phy_reinit_r <= '0;
      busy_r               <= 1'b0;
      done_r               <= 1'b0;
      eseq_err_r           <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      eseq_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          pend_valid_r <= 1'b0;
          if (req_go_s) begin
            if (window_err_s) begin
              eseq_err_r <= 1'b1;
            end else begin
              state_r              <= ACK;
              busy_r               <= 1'b1;
              flit_valid_r         <= 1'b1;
              flit_is_ack_r        <= 1'b1;
              flit_seq_r           <= '0;
              wp_r                 <= bus.wrt_ptr;
              rd_ptr_r             <= req_eseq_s;
              ack_only_r           <= cnt_empty_s | (span_s == '0);
              ack_empty_r          <= cnt_empty_s;
              ack_wrt_ptr_r        <= bus.wrt_ptr;
              ack_num_retry_r      <= bus.num_retry;
              ack_num_phy_reinit_r <= bus.num_phy_reinit;
            end
          end
        end
        ACK: begin
          if (bus.retry_req_valid) begin
            pend_valid_r <= 1'b1;
            pend_eseq_r  <= bus.retry_req_eseq;
          end
          if (handshake_s) begin
            flit_valid_r  <= 1'b0;
            flit_is_ack_r <= 1'b0;
            if (ack_only_r) begin
              // An earlier pending request means this replay is being superseded.
              done_r  <= ~pend_valid_r;
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else if (restart_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r   <= FETCH;
              rd_en_r   <= 1'b1;
              rd_addr_r <= rd_ptr_r;
            end
          end
        end
        FETCH: begin
          if (bus.retry_req_valid) begin
            pend_valid_r <= 1'b1;
            pend_eseq_r  <= bus.retry_req_eseq;
          end
          rd_en_r      <= 1'b0;
          state_r      <= SEND;
          flit_valid_r <= 1'b1;
          flit_seq_r   <= rd_ptr_r;
          first_r      <= 1'b1;
        end
        SEND: begin
          if (bus.retry_req_valid) begin
            pend_valid_r <= 1'b1;
            pend_eseq_r  <= bus.retry_req_eseq;
          end
          first_r <= 1'b0;
          if (first_r) begin
            hold_r <= bus.llrb_rd_data;
          end
          if (handshake_s) begin
            flit_valid_r <= 1'b0;
            flit_seq_r   <= '0;
            hold_r       <= '0;
            rd_ptr_r     <= rd_next_s;
            if (send_last_s) begin
              done_r  <= ~pend_valid_r;
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else if (restart_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end else begin
              state_r   <= FETCH;
              rd_en_r   <= 1'b1;
              rd_addr_r <= rd_next_s;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.llrb_rd_en         = rd_en_r;
  assign bus.llrb_rd_addr       = rd_addr_r;
  assign bus.flit_valid         = flit_valid_r;
  assign bus.flit_is_ack        = flit_is_ack_r;
  assign bus.flit_data          = first_r ? bus.llrb_rd_data : hold_r;
  assign bus.flit_seq           = flit_seq_r;
  assign bus.ack_empty          = ack_empty_r;
  assign bus.ack_wrt_ptr        = ack_wrt_ptr_r;
  assign bus.ack_num_retry      = ack_num_retry_r;
  assign bus.ack_num_phy_reinit = ack_num_phy_reinit_r;
  assign bus.replay_busy        = busy_r;
  assign bus.replay_done        = done_r;
  assign bus.eseq_err           = eseq_err_r;

endmodule
